// File: rtl/max_finder_pkg.sv
// Shared types and helpers for the max_finder family of blocks.
// Index widths use idx_w so that single-entry ranges still get a 1-bit field.
package max_finder_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/argmax_update.sv
// Combinational running-argmax step: keeps the running (value, index) unless the
// incoming value is strictly larger, or 'first' forces a load.
module argmax_update #(
   parameter int VAL_W = 8,
   parameter int IDX_W = 6
) (
   input  logic             first,
   input  logic [VAL_W-1:0] run_value,
   input  logic [IDX_W-1:0] run_index,
   input  logic [VAL_W-1:0] new_value,
   input  logic [IDX_W-1:0] new_index,
   output logic [VAL_W-1:0] sel_value,
   output logic [IDX_W-1:0] sel_index
);

   logic take;

   always_comb begin
      // Strict compare: on ties the earlier entry survives.
      take      = first || (new_value > run_value);
      sel_value = take ? new_value : run_value;
      sel_index = take ? new_index : run_index;
   end

endmodule

// File: rtl/argmax_frame_accumulator.sv
// Reduces a frame of per-beat (max, lane) results into one frame-global max and
// flat index (beat*NUM_INPUTS + lane), presented on a valid/ready output.
module argmax_frame_accumulator
   import max_finder_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int NUM_INPUTS  = 4,
   parameter int FRAME_BEATS = 16
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [WIDTH-1:0]                           in_max_value,
   input  logic [idx_w(NUM_INPUTS)-1:0]               in_max_index,
   input  logic                                       in_last,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [WIDTH-1:0]                           out_max_value,
   output logic [idx_w(NUM_INPUTS*FRAME_BEATS)-1:0]   out_max_index,
   output logic [idx_w(FRAME_BEATS+1)-1:0]            out_beats
);

   localparam int IDX_W  = idx_w(NUM_INPUTS * FRAME_BEATS);
   localparam int BEAT_W = idx_w(FRAME_BEATS + 1);
   localparam int CNT_W  = idx_w(FRAME_BEATS);

   acc_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
   logic [WIDTH-1:0]   run_value_reg, run_value_next;
   logic [IDX_W-1:0]   run_index_reg, run_index_next;
   logic [WIDTH-1:0]   out_value_reg, out_value_next;
   logic [IDX_W-1:0]   out_index_reg, out_index_next;
   logic [BEAT_W-1:0]  out_beats_reg, out_beats_next;

   logic               accept;
   logic               first_beat;
   logic               frame_end;
   logic [IDX_W-1:0]   flat_index;
   logic [WIDTH-1:0]   upd_value;
   logic [IDX_W-1:0]   upd_index;

   // Ready/valid are pure decodes of the registered state.
   assign in_ready      = (state_reg == ACCUM);
   assign out_valid     = (state_reg == HOLD);
   assign out_max_value = out_value_reg;
   assign out_max_index = out_index_reg;
   assign out_beats     = out_beats_reg;

   assign accept     = in_ready && in_valid;
   assign first_beat = (beat_cnt_reg == '0);
   assign frame_end  = in_last || (beat_cnt_reg == CNT_W'(FRAME_BEATS - 1));
   assign flat_index = IDX_W'(beat_cnt_reg) * IDX_W'(NUM_INPUTS) + IDX_W'(in_max_index);

   argmax_update #(
      .VAL_W (WIDTH),
      .IDX_W (IDX_W)
   ) u_update (
      .first     (first_beat),
      .run_value (run_value_reg),
      .run_index (run_index_reg),
      .new_value (in_max_value),
      .new_index (flat_index),
      .sel_value (upd_value),
      .sel_index (upd_index)
   );

   always_comb begin
      state_next     = state_reg;
      beat_cnt_next  = beat_cnt_reg;
      run_value_next = run_value_reg;
      run_index_next = run_index_reg;
      out_value_next = out_value_reg;
      out_index_next = out_index_reg;
      out_beats_next = out_beats_reg;

      case (state_reg)
         ACCUM: begin
            if (accept) begin
               run_value_next = upd_value;
               run_index_next = upd_index;
               if (frame_end) begin
                  out_value_next = upd_value;
                  out_index_next = upd_index;
                  out_beats_next = BEAT_W'(beat_cnt_reg) + BEAT_W'(1);
                  beat_cnt_next  = '0;
                  state_next     = HOLD;
               end else begin
                  beat_cnt_next  = beat_cnt_reg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            // No bypass: the handshake cycle itself never accepts a beat.
            if (out_ready) begin
               state_next = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ACCUM;
         beat_cnt_reg  <= '0;
         run_value_reg <= '0;
         run_index_reg <= '0;
         out_value_reg <= '0;
         out_index_reg <= '0;
         out_beats_reg <= '0;
      end else begin
         state_reg     <= state_next;
         beat_cnt_reg  <= beat_cnt_next;
         run_value_reg <= run_value_next;
         run_index_reg <= run_index_next;
         out_value_reg <= out_value_next;
         out_index_reg <= out_index_next;
         out_beats_reg <= out_beats_next;
      end
   end

endmodule
